// File: rtl/ssd_share_arbiter.sv
// ssd_share_arbiter: round-robin owner of the shared two-digit Pmod seven-segment display.
// Each grant snapshots the requester's byte and holds it for DWELL_CYCLES clocks.
module ssd_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 12000000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       data,
    output logic [7:0]                 disp_value,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy
);
    localparam int OW  = $clog2(NUM_REQ);
    localparam int OW1 = OW + 1;
    localparam logic [OW:0]      NUM_REQ_X = OW1'(NUM_REQ);
    localparam logic [OW-1:0]    LAST_IDX  = OW'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [OW-1:0]      ptr, ptr_n, sel, owner_n, owner_inc;
    logic [OW:0]        idx;
    logic               found;
    logic [7:0]         vals [NUM_REQ];
    logic [7:0]         disp_n;
    logic [NUM_REQ-1:0] grant_n, done_n;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            vals[i] = data[8*i +: 8];
        end
    end

    // First set request at or above ptr, wrapping modulo NUM_REQ
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + OW1'(i);
            if (idx >= NUM_REQ_X) begin
                idx = idx - NUM_REQ_X;
            end
            if (!found && req[idx[OW-1:0]]) begin
                found = 1'b1;
                sel   = idx[OW-1:0];
            end
        end
    end

    assign owner_inc = (owner == LAST_IDX) ? '0 : owner + OW'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        grant_n = grant;
        owner_n = owner;
        disp_n  = disp_value;
        done_n  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = NUM_REQ'(1) << sel;
                    owner_n = sel;
                    disp_n  = vals[sel];
                    cnt_n   = '0;
                    state_n = SHOW;
                end
            end
            SHOW: begin
                cnt_n = cnt + CNT_W'(1);
                // Withdrawal wins over expiry and never produces done
                if (!req[owner]) begin
                    grant_n = '0;
                    ptr_n   = owner_inc;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    grant_n = '0;
                    done_n  = grant;
                    ptr_n   = owner_inc;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            grant      <= '0;
            owner      <= '0;
            disp_value <= '0;
            done       <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            grant      <= grant_n;
            owner      <= owner_n;
            disp_value <= disp_n;
            done       <= done_n;
        end
    end

    assign busy = (state == SHOW);

endmodule

// File: tb/tb_ssd_share_arbiter.sv
// Self-checking bench for ssd_share_arbiter (NUM_REQ=4, DWELL_CYCLES=4) against a
// transaction-level model of grants, dwell age and the round-robin pointer.
module tb_ssd_share_arbiter;
    localparam int N = 4;
    localparam int DW = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] data = '0;
    logic [7:0]   disp_value;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic [N-1:0] done;
    logic         busy;

    int n_chk = 0;
    int n_fail = 0;

    // Model: who is on screen (-1 = nobody), how many cycles it has been shown,
    // next-priority requester, most recent owner, done recipient, snapshotted byte.
    int m_owner, m_age, m_ptr, m_last, m_done;
    logic [7:0] m_val;

    ssd_share_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .disp_value(disp_value), .grant(grant), .owner(owner),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_ptr = 0; m_last = 0; m_done = -1; m_val = 8'h00;
    endtask

    task automatic model_step();
        int c;
        m_done = -1;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_age == DW - 1) begin
                m_done = m_owner;
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else if (req != '0) begin
            c = -1;
            for (int k = 0; k < N; k++) begin
                if (c < 0 && req[(m_ptr + k) % N]) c = (m_ptr + k) % N;
            end
            m_owner = c; m_last = c; m_age = 0; m_val = data[8*c +: 8];
        end
    endtask

    function automatic logic [18:0] exp_vec();
        logic [3:0] g, d;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        d = (m_done >= 0) ? (4'b0001 << m_done) : 4'b0000;
        return {m_val, g, 2'(m_last), d, (m_owner >= 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        req = '0;
        repeat (DW + 2) tick();
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        #12;
        n_chk++;
        if ({disp_value, grant, owner, done, busy} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0", {disp_value, grant, owner, done, busy});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_chk++;
            if ({disp_value, grant, owner, done, busy} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got %h want 0", c, {disp_value, grant, owner, done, busy});
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [3:0] prev_g = '0;
        int seen = 0, dones = 0, cyc = 0;
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        while (seen < 5 && cyc < 80) begin
            tick();
            cyc++;
            n_chk++;
            if ({disp_value, grant, owner, done, busy} !== exp_vec()) begin
                n_fail++;
                $display("FAIL fair_model c%0d: got %h want %h", cyc, {disp_value, grant, owner, done, busy}, exp_vec());
            end
            if (done != '0) dones++;
            if (grant != '0 && prev_g == '0) begin
                n_chk++;
                if (grant !== exp_g[seen] || disp_value !== exp_d[seen]) begin
                    n_fail++;
                    $display("FAIL fair_order #%0d: got grant %b disp %h want %b %h", seen, grant, disp_value, exp_g[seen], exp_d[seen]);
                end
                seen++;
            end
            prev_g = grant;
        end
        n_chk++;
        if (seen != 5 || dones != 4) begin
            n_fail++;
            $display("FAIL fair_count: got grants %0d dones %0d want 5 4", seen, dones);
        end
    endtask

    task automatic test_single();
        int cyc = 0;
        drain();
        data[7:0] = 8'h3A;
        req = 4'b0001;
        while (grant != 4'b0001 && cyc < 10) begin tick(); cyc++; end
        n_chk++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_wait: got grant %b want 0001", grant);
        end
        for (int k = 1; k < DW + 2; k++) begin
            tick();
            n_chk++;
            if ({disp_value, grant, owner, done, busy} !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model k%0d: got %h want %h", k, {disp_value, grant, owner, done, busy}, exp_vec());
            end
            n_chk++;
            if (k < DW && (grant !== 4'b0001 || disp_value !== 8'h3A || done !== 4'b0)) begin
                n_fail++;
                $display("FAIL single_dwell k%0d: got grant %b disp %h done %b want 0001 3a 0000", k, grant, disp_value, done);
            end else if (k == DW && (grant !== 4'b0 || done !== 4'b0001 || busy !== 1'b0)) begin
                n_fail++;
                $display("FAIL single_done: got grant %b done %b busy %b want 0000 0001 0", grant, done, busy);
            end else if (k == DW + 1 && (grant !== 4'b0001 || done !== 4'b0)) begin
                n_fail++;
                $display("FAIL single_regrant: got grant %b done %b want 0001 0000", grant, done);
            end
        end
    endtask

    task automatic test_snapshot_withdraw();
        int cyc = 0;
        drain();
        data[23:16] = 8'h55;
        req = 4'b0100;
        while (grant == '0 && cyc < 10) begin tick(); cyc++; end
        n_chk++;
        if (grant !== 4'b0100 || disp_value !== 8'h55) begin
            n_fail++;
            $display("FAIL snap_grant: got grant %b disp %h want 0100 55", grant, disp_value);
        end
        data[23:16] = 8'hAA;
        tick();
        n_chk++;
        if (grant !== 4'b0100 || disp_value !== 8'h55) begin
            n_fail++;
            $display("FAIL snap_hold: got grant %b disp %h want 0100 55", grant, disp_value);
        end
        req = 4'b1011;
        tick();
        n_chk++;
        if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw: got grant %b done %b busy %b want 0000 0000 0", grant, done, busy);
        end
        tick();
        n_chk++;
        if (grant == 4'b0 || grant[2] !== 1'b0 || {disp_value, grant, owner, done, busy} !== exp_vec()) begin
            n_fail++;
            $display("FAIL withdraw_next: got %h want %h", {disp_value, grant, owner, done, busy}, exp_vec());
        end
    endtask

    task automatic test_reset_mid_show();
        int cyc = 0;
        logic hit = 1'b0;
        drain();
        req = 4'b0010;
        while (grant == '0 && cyc < 10) begin tick(); cyc++; end
        tick();
        tick();
        n_chk++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_show: got grant %b busy %b want 0010 1", grant, busy);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({disp_value, grant, owner, done, busy} !== 19'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %h want 0", {disp_value, grant, owner, done, busy});
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (grant == 4'b0010) hit = 1'b1;
            n_chk++;
            if ({disp_value, grant, owner, done, busy} !== exp_vec() || done !== 4'b0) begin
                n_fail++;
                $display("FAIL rst_after k%0d: got %h want %h", k, {disp_value, grant, owner, done, busy}, exp_vec());
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rst_regrant: got no grant 0010 want grant 0010");
        end
    endtask

    task automatic test_done_cycle();
        int cyc = 0;
        drain();
        req = 4'b1000;
        while (done != 4'b1000 && cyc < 20) begin tick(); cyc++; end
        n_chk++;
        if (done !== 4'b1000) begin
            n_fail++;
            $display("FAIL donecyc_wait: got done %b want 1000", done);
        end
        req = 4'b1001;
        tick();
        n_chk++;
        if (grant !== 4'b0001 || owner !== 2'd0 || {disp_value, grant, owner, done, busy} !== exp_vec()) begin
            n_fail++;
            $display("FAIL donecyc_grant: got grant %b owner %0d want 0001 0", grant, owner);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            data = $urandom();
            tick();
            n_chk++;
            if ({disp_value, grant, owner, done, busy} !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_model c%0d: got %h want %h", c, {disp_value, grant, owner, done, busy}, exp_vec());
            end
            if (!$onehot0(grant) || (done & ~(4'b0001 << owner)) != '0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rand_invariant c%0d: got grant %b done %b owner %0d", c, grant, done, owner);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_snapshot_withdraw();
        test_reset_mid_show();
        test_done_cycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
